// File: rtl/pw_conv_pkg.sv
// Shared types and width/saturation helpers for the pointwise convolution engine.
package pw_conv_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} pw_state_t;

  function automatic int unsigned addr_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int unsigned acc_w(input int unsigned width, input int unsigned chin);
    return 2 * width + $clog2(chin);
  endfunction

  function automatic int sat_max(input int unsigned width);
    return (1 << (width - 1)) - 1;
  endfunction

  function automatic int sat_min(input int unsigned width, input int unsigned relu);
    return (relu != 0) ? 0 : -(1 << (width - 1));
  endfunction

endpackage

// File: rtl/pw_mac_lane.sv
// One output-channel lane: multiply-accumulate (stage 2) and bias/shift/clamp requantisation (stage 3).
module pw_mac_lane
  import pw_conv_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CHIN  = 112,
  parameter int unsigned FRAC  = 14,
  parameter int unsigned RELU  = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      acc_en,
  input  logic                      first,
  input  logic                      out_en,
  input  logic signed [WIDTH-1:0]   pix,
  input  logic signed [WIDTH-1:0]   ker,
  input  logic signed [2*WIDTH-1:0] bias,
  output logic signed [WIDTH-1:0]   ofm
);

  localparam int unsigned AW = acc_w(WIDTH, CHIN);
  // One guard bit so the bias addition can never wrap either.
  localparam int unsigned SW = AW + 1;
  localparam logic signed [SW-1:0] SMAX = SW'(sat_max(WIDTH));
  localparam logic signed [SW-1:0] SMIN = SW'(sat_min(WIDTH, RELU));

  logic signed [2*WIDTH-1:0] prod;
  logic signed [AW-1:0]      acc;
  logic signed [SW-1:0]      sum;
  logic signed [SW-1:0]      shifted;

  assign prod    = pix * ker;
  assign sum     = SW'(acc) + SW'(bias);
  assign shifted = sum >>> FRAC;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc <= '0;
      ofm <= '0;
    end else begin
      if (acc_en) acc <= first ? AW'(prod) : acc + AW'(prod);
      if (out_en) begin
        if (shifted > SMAX)      ofm <= WIDTH'(SMAX);
        else if (shifted < SMIN) ofm <= WIDTH'(SMIN);
        else                     ofm <= WIDTH'(shifted);
      end
    end
  end

endmodule

// File: rtl/pw_conv_engine.sv
// Pointwise (1x1) convolution engine: layer FSM, channel/pixel counters, operand stage and DSP_NO MAC lanes.
module pw_conv_engine
  import pw_conv_pkg::*;
#(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned CHIN   = 112,
  parameter int unsigned DSP_NO = 368,
  parameter int unsigned WOUT   = 8,
  parameter int unsigned FRAC   = 14,
  parameter int unsigned RELU   = 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             en_i,
  input  logic [WIDTH-1:0]                 ifm_i,
  input  logic                             ifm_valid_i,
  output logic [addr_w(CHIN)-1:0]          weight_addr_o,
  input  logic [DSP_NO-1:0][WIDTH-1:0]     weights_i,
  input  logic [DSP_NO-1:0][2*WIDTH-1:0]   bias_i,
  output logic [DSP_NO-1:0][WIDTH-1:0]     ofm_o,
  output logic                             sample_o,
  output logic                             busy_o,
  output logic                             done_o
);

  localparam int unsigned CW = addr_w(CHIN);
  localparam int unsigned PW = addr_w(WOUT * WOUT);
  localparam logic [CW-1:0] CH_LAST  = CW'(CHIN - 1);
  localparam logic [PW-1:0] PIX_LAST = PW'(WOUT * WOUT - 1);

  pw_state_t state_q, state_d;
  logic      accept, last_ch, last_pix, out_en;

  logic [CW-1:0] ch_cnt;
  logic [PW-1:0] pix_cnt;

  logic                         s1_valid, s1_first, s1_last, s1_final;
  logic [WIDTH-1:0]             s1_pix;
  logic [DSP_NO-1:0][WIDTH-1:0] s1_ker;
  logic                         s2_last, s2_final, final_q;

  assign last_ch       = (ch_cnt == CH_LAST);
  assign last_pix      = (pix_cnt == PIX_LAST);
  assign weight_addr_o = ch_cnt;
  // A drop of en_i must stop a result already in stage 3 from reaching ofm_o.
  assign out_en        = s2_last & en_i;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    case (state_q)
      IDLE:  if (en_i) state_d = RUN;
      RUN: begin
        accept = ifm_valid_i & en_i;
        if (accept && last_ch && last_pix) state_d = DRAIN;
      end
      DRAIN: if (final_q) state_d = DONE;
      DONE:  state_d = DONE;
      default: state_d = IDLE;
    endcase
    if (!en_i) state_d = IDLE;
  end

  // Counters, operand stage and pipeline tags; an abort flushes everything but the operand data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ch_cnt   <= '0;
      pix_cnt  <= '0;
      s1_valid <= 1'b0;
      s1_first <= 1'b0;
      s1_last  <= 1'b0;
      s1_final <= 1'b0;
      s1_pix   <= '0;
      s1_ker   <= '0;
      s2_last  <= 1'b0;
      s2_final <= 1'b0;
      final_q  <= 1'b0;
      sample_o <= 1'b0;
      busy_o   <= 1'b0;
      done_o   <= 1'b0;
    end else begin
      busy_o <= (state_d == RUN) || (state_d == DRAIN);
      done_o <= (state_d == DONE);
      if (!en_i) begin
        ch_cnt   <= '0;
        pix_cnt  <= '0;
        s1_valid <= 1'b0;
        s2_last  <= 1'b0;
        s2_final <= 1'b0;
        final_q  <= 1'b0;
        sample_o <= 1'b0;
      end else begin
        s1_valid <= accept;
        if (accept) begin
          s1_pix   <= ifm_i;
          s1_ker   <= weights_i;
          s1_first <= (ch_cnt == '0);
          s1_last  <= last_ch;
          s1_final <= last_ch & last_pix;
          if (last_ch) begin
            ch_cnt  <= '0;
            pix_cnt <= last_pix ? '0 : pix_cnt + PW'(1);
          end else begin
            ch_cnt <= ch_cnt + CW'(1);
          end
        end
        s2_last  <= s1_valid & s1_last;
        s2_final <= s1_valid & s1_final;
        sample_o <= s2_last;
        final_q  <= s2_last & s2_final;
      end
    end
  end

  for (genvar k = 0; k < DSP_NO; k++) begin : g_lane
    pw_mac_lane #(
      .WIDTH(WIDTH),
      .CHIN (CHIN),
      .FRAC (FRAC),
      .RELU (RELU)
    ) u_lane (
      .clk   (clk),
      .rst   (rst),
      .acc_en(s1_valid),
      .first (s1_first),
      .out_en(out_en),
      .pix   (s1_pix),
      .ker   (s1_ker[k]),
      .bias  (bias_i[k]),
      .ofm   (ofm_o[k])
    );
  end

endmodule

// File: tb/tb_pw_conv_engine.sv
// Directed bench for pw_conv_engine: ReLU/CHIN=4, signed-sat/CHIN=4 and ReLU/CHIN=1 instances.
module tb_pw_conv_engine;

  localparam int unsigned W = 16;
  localparam int unsigned N = 4;

  logic clk = 1'b0;
  logic rst;
  logic en_a, en_b, en_c;
  logic [W-1:0] ifm;
  logic valid;
  logic [N-1:0][W-1:0]   weights;
  logic [N-1:0][2*W-1:0] bias;

  logic [1:0] addr_a, addr_b;
  logic [0:0] addr_c;
  logic [N-1:0][W-1:0] ofm_a, ofm_b, ofm_c;
  logic sample_a, sample_b, sample_c;
  logic busy_a, busy_b, busy_c;
  logic done_a, done_b, done_c;

  int ntests = 0;
  int nfail  = 0;

  always #5 clk = ~clk;

  pw_conv_engine #(.WIDTH(16), .CHIN(4), .DSP_NO(4), .WOUT(2), .FRAC(14), .RELU(1)) u_a (
    .clk(clk), .rst(rst), .en_i(en_a), .ifm_i(ifm), .ifm_valid_i(valid),
    .weight_addr_o(addr_a), .weights_i(weights), .bias_i(bias), .ofm_o(ofm_a),
    .sample_o(sample_a), .busy_o(busy_a), .done_o(done_a));

  pw_conv_engine #(.WIDTH(16), .CHIN(4), .DSP_NO(4), .WOUT(2), .FRAC(14), .RELU(0)) u_b (
    .clk(clk), .rst(rst), .en_i(en_b), .ifm_i(ifm), .ifm_valid_i(valid),
    .weight_addr_o(addr_b), .weights_i(weights), .bias_i(bias), .ofm_o(ofm_b),
    .sample_o(sample_b), .busy_o(busy_b), .done_o(done_b));

  pw_conv_engine #(.WIDTH(16), .CHIN(1), .DSP_NO(4), .WOUT(2), .FRAC(14), .RELU(1)) u_c (
    .clk(clk), .rst(rst), .en_i(en_c), .ifm_i(ifm), .ifm_valid_i(valid),
    .weight_addr_o(addr_c), .weights_i(weights), .bias_i(bias), .ofm_o(ofm_c),
    .sample_o(sample_c), .busy_o(busy_c), .done_o(done_c));

  typedef struct {
    int                  sel;
    logic [W-1:0]        ifm;
    logic [W-1:0]        w;
    int                  bias_scale;
    bit                  ramp;
    bit                  stall;
    logic [N-1:0][W-1:0] exp;
  } vec_t;

  vec_t vecs [11];

  task automatic check(input string name, input int act, input int exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [N-1:0][W-1:0] pk(input int l0, input int l1, input int l2, input int l3);
    logic [N-1:0][W-1:0] r;
    r[0] = 16'(l0); r[1] = 16'(l1); r[2] = 16'(l2); r[3] = 16'(l3);
    return r;
  endfunction

  task automatic observe(input int sel, output logic samp, output logic [N-1:0][W-1:0] o,
                         output logic dn, output logic bz, output int ad);
    if (sel == 0) begin
      samp = sample_a; o = ofm_a; dn = done_a; bz = busy_a; ad = int'(addr_a);
    end else begin
      samp = sample_b; o = ofm_b; dn = done_b; bz = busy_b; ad = int'(addr_b);
    end
  endtask

  task automatic set_all(input logic [W-1:0] w, input int bscale);
    for (int k = 0; k < int'(N); k++) begin
      weights[k] = w;
      bias[k]    = 32'(k * bscale);
    end
  endtask

  // Full 4-pixel layer from one table row; the bench tracks its own accepts and expected sample cycles.
  task automatic run_layer(input int vi);
    vec_t v;
    int acc, nsamp, last_samp, addr_bad;
    int exp_q[$];
    bit got_done;
    logic samp, dn, bz;
    logic [N-1:0][W-1:0] o;
    int ad, ec;
    v = vecs[vi];
    set_all(v.w, v.bias_scale);
    @(posedge clk); #1;
    if (v.sel == 0) en_a = 1'b1; else en_b = 1'b1;
    valid = 1'b0;
    acc = 0; nsamp = 0; last_samp = -1; addr_bad = 0; got_done = 1'b0;
    for (int cyc = 1; cyc <= 200; cyc++) begin
      @(posedge clk); #1;
      observe(v.sel, samp, o, dn, bz, ad);
      if (samp) begin
        ec = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
        check($sformatf("v%0d sample_cycle", vi), cyc, ec);
        for (int k = 0; k < int'(N); k++)
          check($sformatf("v%0d ofm lane%0d", vi, k), int'($signed(o[k])), int'($signed(v.exp[k])));
        if (last_samp >= 0)
          check($sformatf("v%0d sample_spacing", vi), cyc - last_samp, v.stall ? 8 : 4);
        last_samp = cyc;
        nsamp++;
      end
      if (dn) begin
        check($sformatf("v%0d done_cycle", vi), cyc, last_samp + 1);
        check($sformatf("v%0d busy_at_done", vi), int'(bz), 0);
        got_done = 1'b1;
        break;
      end
      if (acc < 16 && ad != acc % 4) addr_bad++;
      if (acc < 16 && (!v.stall || (cyc % 2 == 1))) begin
        valid = 1'b1;
        ifm   = v.ramp ? 16'((acc % 4 + 1) * 4096) : v.ifm;
        if (acc % 4 == 3) exp_q.push_back(cyc + 3);
        acc++;
      end else begin
        valid = 1'b0;
        ifm   = 16'h5a5a;
      end
    end
    check($sformatf("v%0d done_seen", vi), int'(got_done), 1);
    check($sformatf("v%0d sample_count", vi), nsamp, 4);
    check($sformatf("v%0d weight_addr_seq", vi), addr_bad, 0);
    valid = 1'b0;
    en_a = 1'b0; en_b = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    observe(v.sel, samp, o, dn, bz, ad);
    check($sformatf("v%0d done_after_en_low", vi), int'(dn), 0);
  endtask

  // Abort dut a after n accepts of 1.0 x 0.25; only pixel 0 (last accept at cycle 4) may emit.
  task automatic abort_run(input int n);
    int nsamp;
    set_all(16'(4096), 0);
    @(posedge clk); #1;
    en_a = 1'b1; valid = 1'b0;
    nsamp = 0;
    for (int cyc = 1; cyc <= n + 20; cyc++) begin
      @(posedge clk); #1;
      if (sample_a) begin
        check($sformatf("abort%0d sample_cycle", n), cyc, 7);
        nsamp++;
      end
      if (cyc == n + 1) begin
        check($sformatf("abort%0d busy_before", n), int'(busy_a), 1);
        check($sformatf("abort%0d addr_before", n), int'(addr_a), n % 4);
      end
      if (cyc == n + 2) begin
        check($sformatf("abort%0d addr_after", n), int'(addr_a), 0);
        check($sformatf("abort%0d busy_after", n), int'(busy_a), 0);
        check($sformatf("abort%0d done_after", n), int'(done_a), 0);
      end
      if (cyc <= n) begin
        valid = 1'b1; ifm = 16'(16384);
      end else begin
        valid = 1'b0; en_a = 1'b0;
      end
    end
    check($sformatf("abort%0d sample_count", n), nsamp, 1);
    check($sformatf("abort%0d ofm_held", n), int'($signed(ofm_a[2])), 16384);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [W-1:0] vals_c [4];
    int exp_c [4];
    int nsamp;
    bit got_done;

    vecs[0]  = '{0, 16'(16384),  16'(4096),   0,       1'b0, 1'b0, pk(16384, 16384, 16384, 16384)};
    vecs[1]  = '{0, 16'(16384),  16'(-4096),  0,       1'b0, 1'b0, pk(0, 0, 0, 0)};
    vecs[2]  = '{0, 16'(16384),  16'(16384),  0,       1'b0, 1'b0, pk(32767, 32767, 32767, 32767)};
    vecs[3]  = '{1, 16'(16384),  16'(-16384), 0,       1'b0, 1'b0, pk(-32768, -32768, -32768, -32768)};
    vecs[4]  = '{0, 16'(16384),  16'(0),      1 << 28, 1'b0, 1'b0, pk(0, 16384, 32767, 32767)};
    vecs[5]  = '{1, 16'(-16384), 16'(4096),   0,       1'b0, 1'b0, pk(-16384, -16384, -16384, -16384)};
    vecs[6]  = '{1, 16'(1),      16'(-1),     0,       1'b0, 1'b0, pk(-1, -1, -1, -1)};
    vecs[7]  = '{0, 16'(3),      16'(2000),   0,       1'b0, 1'b0, pk(1, 1, 1, 1)};
    vecs[8]  = '{0, 16'(0),      16'(4096),   0,       1'b1, 1'b0, pk(10240, 10240, 10240, 10240)};
    vecs[9]  = '{0, 16'(0),      16'(16384),  0,       1'b1, 1'b1, pk(32767, 32767, 32767, 32767)};
    vecs[10] = '{0, 16'(0),      16'(4096),   0,       1'b1, 1'b1, pk(10240, 10240, 10240, 10240)};

    rst = 1'b0; en_a = 1'b0; en_b = 1'b0; en_c = 1'b0;
    valid = 1'b0; ifm = '0; weights = '0; bias = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset sample_a", int'(sample_a), 0);
    check("reset busy_a", int'(busy_a), 0);
    check("reset done_a", int'(done_a), 0);
    check("reset addr_a", int'(addr_a), 0);
    check("reset ofm_a", int'(ofm_a[1]), 0);
    check("reset ofm_c", int'(ofm_c[3]), 0);
    @(negedge clk) rst = 1'b1;

    for (int i = 0; i < 11; i++) run_layer(i);

    abort_run(6);
    abort_run(8);
    run_layer(0);

    // CHIN=1: one pixel per accept, 0.5 weights halve the input.
    vals_c[0] = 16'(16384); vals_c[1] = 16'(2000); vals_c[2] = 16'(-100); vals_c[3] = 16'(3);
    exp_c[0]  = 8192;       exp_c[1]  = 1000;      exp_c[2]  = 0;         exp_c[3]  = 1;
    set_all(16'(8192), 0);
    @(posedge clk); #1;
    en_c = 1'b1; valid = 1'b0;
    nsamp = 0; got_done = 1'b0;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      @(posedge clk); #1;
      if (sample_c) begin
        check("chin1 sample_cycle", cyc, nsamp + 4);
        if (nsamp < 4)
          for (int k = 0; k < int'(N); k++)
            check($sformatf("chin1 p%0d lane%0d", nsamp, k), int'($signed(ofm_c[k])), exp_c[nsamp]);
        nsamp++;
      end
      if (done_c) begin
        check("chin1 done_cycle", cyc, 8);
        got_done = 1'b1;
        break;
      end
      if (cyc <= 4) begin
        valid = 1'b1; ifm = vals_c[cyc-1];
      end else begin
        valid = 1'b0;
      end
    end
    check("chin1 done_seen", int'(got_done), 1);
    check("chin1 sample_count", nsamp, 4);
    en_c = 1'b0; valid = 1'b0;

    // Asynchronous reset in the middle of pixel 1.
    set_all(16'(4096), 0);
    @(posedge clk); #1;
    en_a = 1'b1;
    for (int cyc = 1; cyc <= 5; cyc++) begin
      @(posedge clk); #1;
      valid = 1'b1; ifm = 16'(16384);
    end
    @(posedge clk); #1;
    check("pre_reset busy_a", int'(busy_a), 1);
    check("pre_reset addr_a", int'(addr_a), 1);
    rst = 1'b0;
    #1;
    check("async_reset busy_a", int'(busy_a), 0);
    check("async_reset addr_a", int'(addr_a), 0);
    check("async_reset sample_a", int'(sample_a), 0);
    check("async_reset done_a", int'(done_a), 0);
    for (int k = 0; k < int'(N); k++)
      check($sformatf("async_reset ofm lane%0d", k), int'(ofm_a[k]), 0);
    valid = 1'b0; en_a = 1'b0;
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    check("post_reset busy_a", int'(busy_a), 0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
